hpc_poll_master: RTL and testbench
==================================

# hpc_poll_master

Avalon-MM master that drives the register window of the testbench wrapper from inside the fabric, replacing host software for self-contained runs. It optionally writes the control word (reset/enable/freeze bits), then sweeps the four status registers and presents them as one coherent snapshot with a valid pulse. A periodic auto-poll mode and a version check let on-chip monitors track the data and event counters without CPU involvement.

## Interface
- READ_LATENCY, 1: fixed slave read latency in cycles (1..4)
- EXPECTED_VERSION, 20: value the version register must return
- POLL_CYCLES, 1024: idle cycles between auto-poll sweeps (≥1)
- TIMEOUT, 255: max consecutive waitrequest-high cycles before abort (≥1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  sweep request
- cmd_ready  out  1  high in IDLE only
- cmd_wr_ctrl  in  1  1: write cmd_ctrl to address 0x0 before the reads
- cmd_ctrl  in  32  control word (bit0 reset, bit1 enable, bit2 freeze)
- auto_poll  in  1  enable periodic read-only sweeps
- master_address  out  5  byte address
- master_read  out  1  read request
- master_write  out  1  write request
- master_writedata  out  32  write data
- master_waitrequest  in  1  slave stall (tie 0 for the wrapper)
- master_readdata  in  32  read data
- snap_data_ctr  out  32  value read from 0x4
- snap_event_ctr  out  32  value read from 0x8
- snap_version  out  32  value read from 0xC
- snap_debug  out  32  value read from 0x10
- snap_valid  out  1  one-cycle pulse: snapshot updated
- version_err  out  1  last snapshot version ≠ EXPECTED_VERSION
- timeout_err  out  1  sticky; cleared on next accepted command
- sweep_ctr  out  16  completed sweeps, wraps 0xFFFF→0

## Operation
- States: IDLE, WRITE, RD_REQ, RD_WAIT, DONE. Read index 0..3 maps to 0x4, 0x8, 0xC, 0x10.
- IDLE: cmd_ready=1. cmd_valid accepted → WRITE if cmd_wr_ctrl else RD_REQ, index=0, timeout_err cleared. Else if auto_poll and poll timer reaches POLL_CYCLES → RD_REQ (read-only sweep).
- Poll timer counts only in IDLE with auto_poll=1; clears on leaving IDLE, on auto_poll=0, and on command acceptance. cmd_valid beats timer expiry in the same cycle.
- WRITE: master_write=1, address 0x0, writedata=cmd_ctrl latched at acceptance. Leaves to RD_REQ when waitrequest=0.
- RD_REQ: master_read=1, address per index. Accepted when waitrequest=0 → RD_WAIT, latency counter loaded with READ_LATENCY.
- RD_WAIT: no request asserted; master_readdata captured into a staging register on the last latency cycle. index<3 → RD_REQ with index+1; index=3 → DONE.
- DONE: staging copied to the four snap_* outputs as a set, snap_valid=1, version_err updated, sweep_ctr+1 → IDLE. snap_* only change in DONE (never partially updated).
- Address/read/write/writedata held stable while waitrequest=1. read and write never high together; both low outside WRITE/RD_REQ.
- Timeout: waitrequest high for TIMEOUT consecutive cycles in WRITE or RD_REQ → drop request, timeout_err=1, → IDLE; snap_* unchanged, no snap_valid, sweep_ctr unchanged.
- cmd_valid outside IDLE is ignored (not queued).

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0 (snap_*, snap_valid, version_err, timeout_err, sweep_ctr, master_*), poll timer 0. Reset mid-sweep aborts immediately, with no further bus activity.
- With waitrequest=0, READ_LATENCY=1, command accepted at edge 0: write in cycle 1; reads in cycles 2,4,6,8; snap_valid in cycle 10; cmd_ready high in cycle 11.
- Read-only sweep: reads in cycles 1,3,5,7; snap_valid in cycle 9.
- Generally: sweep length = (cmd_wr_ctrl) + 4·(1+READ_LATENCY) + 1 cycles plus stall cycles.
- Auto-poll: consecutive sweeps start POLL_CYCLES IDLE cycles apart.

## Test plan
- Wrapper slave, cmd_wr_ctrl=1, cmd_ctrl=0x2 -> write 0x2 to 0x0 in cycle 1; snap_version=20, version_err=0, snap_valid in cycle 10, sweep_ctr=1.
- Model slave returning 0x11,0x22,0x15,0x44 at 0x4..0x10, read-only -> snap_*=0x11/0x22/0x15/0x44, version_err=1, snap_valid in cycle 9.
- waitrequest high 3 cycles on the 0x8 read -> address/read held stable, snapshot correct, snap_valid 3 cycles later.
- waitrequest stuck high, TIMEOUT=255 -> abort after 255 cycles, timeout_err=1, no snap_valid; next command clears timeout_err.
- auto_poll=1, POLL_CYCLES=16, cmd_valid on the expiry cycle -> command sweep runs (write issued), timer restarts; subsequent sweeps 16 idle cycles apart.
- reset asserted during RD_WAIT of index 2 -> same cycle master_read=0, all outputs 0; sweep_ctr preset to 0xFFFF then one sweep -> wraps to 0.

Source files
------------

// File: rtl/hpc_poll_master_if.sv
// rtl/hpc_poll_master_if.sv - Avalon-MM bus between the poll master and the register window
interface hpc_poll_master_if;
    logic [4:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata,
        output waitrequest, readdata
    );
endinterface

// File: rtl/hpc_poll_master.sv
// rtl/hpc_poll_master.sv - Avalon-MM poll master that sweeps the wrapper status registers
module hpc_poll_master #(
    parameter int READ_LATENCY     = 1,
    parameter int EXPECTED_VERSION = 20,
    parameter int POLL_CYCLES      = 1024,
    parameter int TIMEOUT          = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr_ctrl,
    input  logic [31:0]       cmd_ctrl,
    input  logic              auto_poll,
    hpc_poll_master_if.master bus,
    output logic [31:0]       snap_data_ctr,
    output logic [31:0]       snap_event_ctr,
    output logic [31:0]       snap_version,
    output logic [31:0]       snap_debug,
    output logic              snap_valid,
    output logic              version_err,
    output logic              timeout_err,
    output logic [15:0]       sweep_ctr
);
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);
    localparam int POLL_W = $clog2(POLL_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        idx;
    logic [LAT_W-1:0]  lat_cnt;
    logic [POLL_W-1:0] poll_cnt;
    logic [TO_W-1:0]   stall_cnt;
    logic [31:0]       ctrl_q;
    logic [31:0]       stage [4];

    logic accept;
    logic poll_fire;
    logic bus_req;
    logic stall_abort;
    logic lat_last;

    // A command always wins over a timer expiry in the same IDLE cycle.
    assign accept      = (state == IDLE) && cmd_valid;
    assign poll_fire   = (state == IDLE) && !cmd_valid && auto_poll &&
                         (poll_cnt == POLL_W'(POLL_CYCLES - 1));
    assign bus_req     = (state == WRITE) || (state == RD_REQ);
    assign stall_abort = bus_req && bus.waitrequest && (stall_cnt == TO_W'(TIMEOUT - 1));
    assign lat_last    = (lat_cnt == LAT_W'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and bus request decode; requests are pure functions of state so they hold during stalls
    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = 5'd0;
        bus.writedata = 32'd0;
        snap_valid    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (accept) begin
                    state_nxt = cmd_wr_ctrl ? WRITE : RD_REQ;
                end else if (poll_fire) begin
                    state_nxt = RD_REQ;
                end
            end
            WRITE: begin
                bus.write     = 1'b1;
                bus.writedata = ctrl_q;
                if (!bus.waitrequest) begin
                    state_nxt = RD_REQ;
                end else if (stall_abort) begin
                    state_nxt = IDLE;
                end
            end
            RD_REQ: begin
                bus.read    = 1'b1;
                bus.address = 5'({idx, 2'b00}) + 5'd4;
                if (!bus.waitrequest) begin
                    state_nxt = RD_WAIT;
                end else if (stall_abort) begin
                    state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                if (lat_last) begin
                    state_nxt = (idx == 2'd3) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                snap_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Poll timer counts IDLE cycles with auto-poll on, restarting whenever a sweep starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt <= '0;
        end else if ((state == IDLE) && auto_poll && !accept && !poll_fire) begin
            poll_cnt <= poll_cnt + 1'b1;
        end else begin
            poll_cnt <= '0;
        end
    end

    // Consecutive-stall counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (bus_req && bus.waitrequest && !stall_abort) begin
                stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end
            if (accept) begin
                timeout_err <= 1'b0;
            end else if (stall_abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Control word latch, read index and read latency countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= 32'd0;
            idx     <= 2'd0;
            lat_cnt <= '0;
        end else begin
            if (accept) begin
                ctrl_q <= cmd_ctrl;
            end
            if (accept || poll_fire) begin
                idx <= 2'd0;
            end else if ((state == RD_WAIT) && lat_last) begin
                idx <= idx + 2'd1;
            end
            if ((state == RD_REQ) && !bus.waitrequest) begin
                lat_cnt <= LAT_W'(READ_LATENCY);
            end else if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

    // Stage each read, then publish all four values together as the sweep enters DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                stage[i] <= 32'd0;
            end
            snap_data_ctr  <= 32'd0;
            snap_event_ctr <= 32'd0;
            snap_version   <= 32'd0;
            snap_debug     <= 32'd0;
            version_err    <= 1'b0;
            sweep_ctr      <= 16'd0;
        end else if ((state == RD_WAIT) && lat_last) begin
            stage[idx] <= bus.readdata;
            if (idx == 2'd3) begin
                snap_data_ctr  <= stage[0];
                snap_event_ctr <= stage[1];
                snap_version   <= stage[2];
                snap_debug     <= bus.readdata;
                version_err    <= (stage[2] != 32'(EXPECTED_VERSION));
                sweep_ctr      <= sweep_ctr + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_hpc_poll_master.sv
// tb/tb_hpc_poll_master.sv - self-checking bench for hpc_poll_master with a sweep-level model
module tb_hpc_poll_master;
    localparam int RL   = 1;
    localparam int EXPV = 20;
    localparam int POLL = 16;
    localparam int TMO  = 255;

    localparam int OP_W    = 0;
    localparam int OP_R    = 1;
    localparam int OP_LAT  = 2;
    localparam int OP_DONE = 3;

    typedef struct {
        int         kind;
        logic [4:0] addr;
        logic [31:0] data;
        int         idx;
        bit         last;
    } op_t;

    typedef struct {
        bit         v;
        logic [4:0] a;
    } rp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr_ctrl;
    logic [31:0] cmd_ctrl;
    logic        auto_poll;
    logic [31:0] snap_data_ctr;
    logic [31:0] snap_event_ctr;
    logic [31:0] snap_version;
    logic [31:0] snap_debug;
    logic        snap_valid;
    logic        version_err;
    logic        timeout_err;
    logic [15:0] sweep_ctr;

    hpc_poll_master_if bus ();

    hpc_poll_master #(
        .READ_LATENCY    (RL),
        .EXPECTED_VERSION(EXPV),
        .POLL_CYCLES     (POLL),
        .TIMEOUT         (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_wr_ctrl   (cmd_wr_ctrl),
        .cmd_ctrl      (cmd_ctrl),
        .auto_poll     (auto_poll),
        .bus           (bus),
        .snap_data_ctr (snap_data_ctr),
        .snap_event_ctr(snap_event_ctr),
        .snap_version  (snap_version),
        .snap_debug    (snap_debug),
        .snap_valid    (snap_valid),
        .version_err   (version_err),
        .timeout_err   (timeout_err),
        .sweep_ctr     (sweep_ctr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: the remaining bus operations of the current sweep, plus the published results.
    op_t         ops[$];
    int          m_timer;
    int          m_stall;
    logic [31:0] m_stage [4];
    logic [31:0] m_snap [4];
    bit          m_verr;
    bit          m_terr;
    logic [15:0] m_sctr;
    int          accept_cyc;

    // Slave: register window plus a read-data pipeline of depth RL.
    logic [31:0] sregs [5];
    rp_t         rpipe[$];

    // Stimulus controls.
    bit          s_rst;
    bit          s_cmd_valid;
    bit          s_wr;
    logic [31:0] s_ctrl;
    bit          s_auto;
    int          s_wmode;
    int          s_wpct;
    int          stall_left;
    logic [4:0]  stall_addr;

    // Observations of the DUT for the literal timing checks.
    int read_cycs[$];
    int write_cycs[$];
    int done_cycs[$];
    int n_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int first_after(input int q[$], input int c);
        foreach (q[i]) begin
            if (q[i] > c) return q[i];
        end
        return -1;
    endfunction

    task automatic clear_obs();
        read_cycs.delete();
        write_cycs.delete();
        done_cycs.delete();
        n_valid = 0;
    endtask

    task automatic model_reset();
        ops.delete();
        m_timer = 0;
        m_stall = 0;
        for (int i = 0; i < 4; i++) begin
            m_stage[i] = 32'd0;
            m_snap[i]  = 32'd0;
        end
        m_verr = 1'b0;
        m_terr = 1'b0;
        m_sctr = 16'd0;
        rpipe.delete();
        for (int i = 0; i < RL; i++) rpipe.push_back('{v: 1'b0, a: 5'd0});
    endtask

    task automatic build_sweep(input bit wr, input logic [31:0] ctrl);
        if (wr) ops.push_back('{kind: OP_W, addr: 5'd0, data: ctrl, idx: 0, last: 1'b0});
        for (int i = 0; i < 4; i++) begin
            ops.push_back('{kind: OP_R, addr: 5'(4 * (i + 1)), data: 32'd0, idx: i, last: 1'b0});
            for (int k = 1; k <= RL; k++) begin
                ops.push_back('{kind: OP_LAT, addr: 5'd0, data: 32'd0, idx: i, last: (k == RL)});
            end
        end
        ops.push_back('{kind: OP_DONE, addr: 5'd0, data: 32'd0, idx: 0, last: 1'b0});
    endtask

    task automatic advance_model();
        op_t h;
        if (ops.size() == 0) begin
            if (cmd_valid) begin
                build_sweep(cmd_wr_ctrl, cmd_ctrl);
                m_terr     = 1'b0;
                m_timer    = 0;
                accept_cyc = cyc;
            end else if (auto_poll) begin
                if (m_timer == POLL - 1) begin
                    build_sweep(1'b0, 32'd0);
                    m_timer = 0;
                end else begin
                    m_timer++;
                end
            end else begin
                m_timer = 0;
            end
        end else begin
            h = ops[0];
            if (h.kind == OP_W || h.kind == OP_R) begin
                if (bus.waitrequest) begin
                    m_stall++;
                    if (m_stall == TMO) begin
                        ops.delete();
                        m_stall = 0;
                        m_terr  = 1'b1;
                    end
                end else begin
                    m_stall = 0;
                    void'(ops.pop_front());
                end
            end else if (h.kind == OP_LAT) begin
                if (h.last) begin
                    m_stage[h.idx] = bus.readdata;
                    if (h.idx == 3) begin
                        m_snap = m_stage;
                        m_verr = (m_stage[2] != 32'(EXPV));
                        m_sctr = m_sctr + 16'd1;
                    end
                end
                void'(ops.pop_front());
            end else begin
                void'(ops.pop_front());
            end
        end
    endtask

    task automatic check_outputs();
        op_t h;
        bit  idle;
        idle = (ops.size() == 0);
        if (!idle) h = ops[0];
        chk("cmd_ready", cmd_ready, idle);
        chk("master_read", bus.read, !idle && h.kind == OP_R);
        chk("master_write", bus.write, !idle && h.kind == OP_W);
        if (!idle && h.kind == OP_R) chk("read_address", bus.address, h.addr);
        if (!idle && h.kind == OP_W) begin
            chk("write_address", bus.address, 5'd0);
            chk("writedata", bus.writedata, h.data);
        end
        chk("snap_valid", snap_valid, !idle && h.kind == OP_DONE);
        chk("snap_data_ctr", snap_data_ctr, m_snap[0]);
        chk("snap_event_ctr", snap_event_ctr, m_snap[1]);
        chk("snap_version", snap_version, m_snap[2]);
        chk("snap_debug", snap_debug, m_snap[3]);
        chk("version_err", version_err, m_verr);
        chk("timeout_err", timeout_err, m_terr);
        chk("sweep_ctr", sweep_ctr, m_sctr);
        if (snap_valid) begin
            n_valid++;
            done_cycs.push_back(cyc);
        end
        if (bus.read) read_cycs.push_back(cyc);
        if (bus.write) write_cycs.push_back(cyc);
    endtask

    // One clock cycle: compare at the falling edge, then drive this cycle's inputs and advance the model.
    task automatic step();
        rp_t rp;
        bit  w;
        @(negedge clk);
        cyc++;
        check_outputs();
        rst         = s_rst;
        cmd_valid   = s_cmd_valid;
        cmd_wr_ctrl = s_wr;
        cmd_ctrl    = s_ctrl;
        auto_poll   = s_auto;
        w = 1'b0;
        if (s_wmode == 0) begin
            w = ($urandom_range(99) < s_wpct);
        end else if (s_wmode == 1) begin
            w = 1'b1;
        end else if (ops.size() > 0 && ops[0].kind == OP_R && ops[0].addr == stall_addr && stall_left > 0) begin
            w = 1'b1;
            stall_left--;
        end
        bus.waitrequest = w;
        rp = rpipe.pop_front();
        bus.readdata = rp.v ? sregs[rp.a >> 2] : $urandom();
        rpipe.push_back('{v: bus.read && !w, a: bus.address});
        if (bus.write && !w) sregs[0] = bus.writedata;
        if (s_rst) model_reset();
        else advance_model();
    endtask

    task automatic issue(input bit wr, input logic [31:0] ctrl);
        s_cmd_valid = 1'b1;
        s_wr        = wr;
        s_ctrl      = ctrl;
        step();
        s_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        s_cmd_valid = 1'b0;
        s_auto      = 1'b0;
        s_wmode     = 0;
        s_wpct      = 0;
        k = 0;
        while (ops.size() != 0 && k < 600) begin
            step();
            k++;
        end
        chk("drain_idle", ops.size(), 0);
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int acc, d0, d1, r1, r2, k;
        bit reached;

        rst = 1'b1;
        s_rst = 1'b1;
        s_cmd_valid = 1'b0;
        s_wr = 1'b0;
        s_ctrl = 32'd0;
        s_auto = 1'b0;
        s_wmode = 0;
        s_wpct = 0;
        stall_left = 0;
        stall_addr = 5'd0;
        cmd_valid = 1'b0;
        cmd_wr_ctrl = 1'b0;
        cmd_ctrl = 32'd0;
        auto_poll = 1'b0;
        bus.waitrequest = 1'b0;
        bus.readdata = 32'd0;
        sregs[0] = 32'd0;
        sregs[1] = 32'h100;
        sregs[2] = 32'h200;
        sregs[3] = 32'(EXPV);
        sregs[4] = 32'hDEB;
        model_reset();

        // Reset state
        repeat (3) step();
        chk("rst_read", bus.read, 1'b0);
        chk("rst_write", bus.write, 1'b0);
        chk("rst_address", bus.address, 5'd0);
        chk("rst_writedata", bus.writedata, 32'd0);
        chk("rst_snap_data", snap_data_ctr, 32'd0);
        chk("rst_sweep_ctr", sweep_ctr, 16'd0);
        chk("rst_snap_valid", snap_valid, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        s_rst = 1'b0;
        repeat (2) step();

        // Write plus sweep against the wrapper contents
        clear_obs();
        issue(1'b1, 32'h2);
        acc = cyc;
        repeat (12) step();
        chk("t1_nwrites", write_cycs.size(), 1);
        if (write_cycs.size() > 0) chk("t1_write_cycle", write_cycs[0] - acc, 1);
        chk("t1_nreads", read_cycs.size(), 4);
        for (int i = 0; i < 4 && i < read_cycs.size(); i++) chk("t1_read_cycle", read_cycs[i] - acc, 2 + 2 * i);
        chk("t1_valid_cycle", first_after(done_cycs, acc) - acc, 10);
        chk("t1_ctrl_written", sregs[0], 32'h2);
        chk("t1_snap_version", snap_version, 32'd20);
        chk("t1_version_err", version_err, 1'b0);
        chk("t1_sweep_ctr", sweep_ctr, 16'd1);

        // Read-only sweep with a wrong version
        sregs[1] = 32'h11;
        sregs[2] = 32'h22;
        sregs[3] = 32'h15;
        sregs[4] = 32'h44;
        clear_obs();
        issue(1'b0, 32'd0);
        acc = cyc;
        repeat (11) step();
        chk("t2_nreads", read_cycs.size(), 4);
        for (int i = 0; i < 4 && i < read_cycs.size(); i++) chk("t2_read_cycle", read_cycs[i] - acc, 1 + 2 * i);
        chk("t2_valid_cycle", first_after(done_cycs, acc) - acc, 9);
        chk("t2_snap_data", snap_data_ctr, 32'h11);
        chk("t2_snap_event", snap_event_ctr, 32'h22);
        chk("t2_snap_version", snap_version, 32'h15);
        chk("t2_snap_debug", snap_debug, 32'h44);
        chk("t2_version_err", version_err, 1'b1);

        // Three stall cycles on the 0x8 read
        sregs[3] = 32'(EXPV);
        s_wmode = 2;
        stall_addr = 5'h8;
        stall_left = 3;
        clear_obs();
        issue(1'b0, 32'd0);
        acc = cyc;
        repeat (14) step();
        chk("t3_read_high_cycles", read_cycs.size(), 7);
        chk("t3_valid_cycle", first_after(done_cycs, acc) - acc, 12);
        chk("t3_snap_event", snap_event_ctr, 32'h22);
        chk("t3_version_err", version_err, 1'b0);
        s_wmode = 0;

        // Waitrequest stuck high until timeout
        s_wmode = 1;
        clear_obs();
        issue(1'b0, 32'd0);
        repeat (260) step();
        chk("t4_timeout_err", timeout_err, 1'b1);
        chk("t4_no_snap_valid", n_valid, 0);
        chk("t4_read_high_cycles", read_cycs.size(), 255);
        chk("t4_sweep_ctr", sweep_ctr, 16'd3);
        s_wmode = 0;
        s_wpct = 0;
        issue(1'b0, 32'd0);
        step();
        chk("t4_timeout_cleared", timeout_err, 1'b0);
        repeat (10) step();

        // Auto-poll with a command landing on the expiry cycle
        drain();
        clear_obs();
        s_auto = 1'b1;
        k = 0;
        while (!(ops.size() == 0 && m_timer == POLL - 1) && k < 100) begin
            step();
            k++;
        end
        reached = (ops.size() == 0 && m_timer == POLL - 1);
        chk("t5_expiry_reached", reached, 1'b1);
        clear_obs();
        issue(1'b1, 32'h5);
        acc = cyc;
        repeat (70) step();
        chk("t5_write_cycle", first_after(write_cycs, acc) - acc, 1);
        d0 = first_after(done_cycs, acc);
        chk("t5_cmd_valid_cycle", d0 - acc, 10);
        r1 = first_after(read_cycs, d0);
        chk("t5_gap1", r1 - d0 - 1, POLL);
        d1 = first_after(done_cycs, d0);
        r2 = first_after(read_cycs, d1);
        chk("t5_gap2", r2 - d1 - 1, POLL);
        s_auto = 1'b0;

        // Randomised traffic
        drain();
        s_wmode = 0;
        s_wpct = 20;
        for (int n = 0; n < 3000; n++) begin
            if (n % 400 == 0) s_auto = $urandom_range(1);
            s_cmd_valid = s_auto ? ($urandom_range(39) == 0) : ($urandom_range(7) == 0);
            s_wr = $urandom_range(1);
            s_ctrl = $urandom();
            if ($urandom_range(9) == 0) sregs[1] = sregs[1] + 32'd1;
            if ($urandom_range(9) == 0) sregs[2] = $urandom();
            if ($urandom_range(19) == 0) sregs[3] = ($urandom_range(3) == 0) ? 32'd21 : 32'(EXPV);
            if ($urandom_range(19) == 0) sregs[4] = $urandom();
            step();
        end
        s_cmd_valid = 1'b0;

        // Reset during RD_WAIT of index 2
        drain();
        issue(1'b0, 32'd0);
        k = 0;
        while (!(ops.size() > 0 && ops[0].kind == OP_LAT && ops[0].idx == 2) && k < 20) begin
            step();
            k++;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        s_rst = 1'b1;
        #1;
        chk("t6_read_low", bus.read, 1'b0);
        chk("t6_write_low", bus.write, 1'b0);
        chk("t6_address", bus.address, 5'd0);
        chk("t6_snap_data", snap_data_ctr, 32'd0);
        chk("t6_snap_debug", snap_debug, 32'd0);
        chk("t6_snap_valid", snap_valid, 1'b0);
        chk("t6_version_err", version_err, 1'b0);
        chk("t6_sweep_ctr", sweep_ctr, 16'd0);
        model_reset();
        repeat (2) step();
        s_rst = 1'b0;
        clear_obs();
        repeat (4) step();
        chk("t6_no_bus_activity", read_cycs.size() + write_cycs.size(), 0);

        // Sweep counter wrap
        force dut.sweep_ctr = 16'hFFFF;
        #1;
        release dut.sweep_ctr;
        m_sctr = 16'hFFFF;
        step();
        issue(1'b0, 32'd0);
        repeat (11) step();
        chk("t7_sweep_wrap", sweep_ctr, 16'd0);

        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
